// File: rtl/race_pkg.sv
// Shared types for the drag-racing game-flow controller: state encoding, winner codes, default widths.
package race_pkg;

    localparam int unsigned TIME_W_DEF = 20;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RACE      = 3'd2,
        ST_RESULT    = 3'd3
    } race_state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2,
        WIN_TIE  = 2'd3
    } winner_t;

    // A dnf player can never win; otherwise the strictly faster time wins, equal times tie.
    function automatic winner_t pick_winner(input logic dnf1, input logic dnf2,
                                            input logic p1_faster, input logic p2_faster);
        if (dnf1 && dnf2) return WIN_NONE;
        if (dnf1)         return WIN_P2;
        if (dnf2)         return WIN_P1;
        if (p1_faster)    return WIN_P1;
        if (p2_faster)    return WIN_P2;
        return WIN_TIE;
    endfunction

endpackage

// File: rtl/ms_sat_counter.sv
// Millisecond counter with synchronous clear, count enable, freeze override and saturation at all-ones.
module ms_sat_counter #(
    parameter int unsigned W = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         freeze,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX = '1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !freeze && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/race_sequencer.sv
// Game-flow controller: start-light countdown, player gating, finish timing and winner latch.
// Optional FALSE_START_EN: throttle during the final light disqualifies that player.
module race_sequencer
    import race_pkg::*;
#(
    parameter int unsigned FINISH_LINE_POS = 1200,
    parameter int unsigned NUM_LIGHTS      = 5,
    parameter int unsigned LIGHT_MS        = 1000,
    parameter int unsigned RACE_TIMEOUT_MS = 30000,
    parameter int unsigned TIME_W          = TIME_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick_ms,
    input  logic              start_game,
    input  logic              back_to_menu,
    input  logic              p1_throttle,
    input  logic              p2_throttle,
    input  logic [31:0]       p1_pos,
    input  logic [31:0]       p2_pos,
    output logic [2:0]        state,
    output logic [2:0]        lights_on,
    output logic              p1_enable,
    output logic              p2_enable,
    output logic [TIME_W-1:0] p1_time_ms,
    output logic [TIME_W-1:0] p2_time_ms,
    output logic              p1_dnf,
    output logic              p2_dnf,
    output logic [1:0]        winner,
    output logic              restart
);

    race_state_t       state_q, state_d;
    logic [2:0]        lights_d;
    logic              p1_en_d, p2_en_d, p1_dnf_d, p2_dnf_d, restart_d;
    winner_t           winner_q, winner_d;
    logic [TIME_W-1:0] phase_cnt;
    logic              phase_clear, phase_tick, light_step, timeout;
    logic              p1_hit, p2_hit, p1_tick, p2_tick, time_clear;

    assign phase_tick = tick_ms && ((state_q == ST_COUNTDOWN) || (state_q == ST_RACE));
    assign light_step = tick_ms && (phase_cnt == TIME_W'(LIGHT_MS - 1));
    assign timeout    = tick_ms && (phase_cnt == TIME_W'(RACE_TIMEOUT_MS - 1));
    assign p1_hit     = (state_q == ST_RACE) && p1_enable && (p1_pos >= 32'(FINISH_LINE_POS));
    assign p2_hit     = (state_q == ST_RACE) && p2_enable && (p2_pos >= 32'(FINISH_LINE_POS));
    assign p1_tick    = (state_q == ST_RACE) && p1_enable && tick_ms;
    assign p2_tick    = (state_q == ST_RACE) && p2_enable && tick_ms;
    assign time_clear = (state_d == ST_IDLE);

`ifndef FALSE_START_EN
    logic unused_throttle;
    assign unused_throttle = p1_throttle ^ p2_throttle;
`endif

    // Shared countdown / race-duration counter
    ms_sat_counter #(.W(TIME_W)) u_phase_cnt (
        .clk(clk), .reset(reset), .clear(phase_clear), .enable(phase_tick),
        .freeze(1'b0), .count(phase_cnt)
    );

    // Player timers; a tick landing on the finish cycle is swallowed by freeze
    ms_sat_counter #(.W(TIME_W)) u_p1_time (
        .clk(clk), .reset(reset), .clear(time_clear), .enable(p1_tick),
        .freeze(p1_hit), .count(p1_time_ms)
    );

    ms_sat_counter #(.W(TIME_W)) u_p2_time (
        .clk(clk), .reset(reset), .clear(time_clear), .enable(p2_tick),
        .freeze(p2_hit), .count(p2_time_ms)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            lights_on <= '0;
            p1_enable <= 1'b0;
            p2_enable <= 1'b0;
            p1_dnf    <= 1'b0;
            p2_dnf    <= 1'b0;
            winner_q  <= WIN_NONE;
            restart   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lights_on <= lights_d;
            p1_enable <= p1_en_d;
            p2_enable <= p2_en_d;
            p1_dnf    <= p1_dnf_d;
            p2_dnf    <= p2_dnf_d;
            winner_q  <= winner_d;
            restart   <= restart_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lights_d    = lights_on;
        p1_en_d     = p1_enable;
        p2_en_d     = p2_enable;
        p1_dnf_d    = p1_dnf;
        p2_dnf_d    = p2_dnf;
        winner_d    = winner_q;
        restart_d   = 1'b0;
        phase_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_game) state_d = ST_COUNTDOWN;
            end
            ST_COUNTDOWN: begin
`ifdef FALSE_START_EN
                if (lights_on == 3'(NUM_LIGHTS)) begin
                    if (p1_throttle) p1_dnf_d = 1'b1;
                    if (p2_throttle) p2_dnf_d = 1'b1;
                end
`endif
                if (light_step) begin
                    phase_clear = 1'b1;
                    if (lights_on == 3'(NUM_LIGHTS)) begin
                        lights_d = '0;
                        p1_en_d  = !p1_dnf_d;
                        p2_en_d  = !p2_dnf_d;
                        state_d  = (p1_dnf_d && p2_dnf_d) ? ST_RESULT : ST_RACE;
                        winner_d = pick_winner(p1_dnf_d, p2_dnf_d, 1'b0, 1'b0);
                    end else begin
                        lights_d = lights_on + 3'd1;
                    end
                end
                if (back_to_menu) state_d = ST_IDLE;
            end
            ST_RACE: begin
                p1_en_d = p1_enable && !p1_hit;
                p2_en_d = p2_enable && !p2_hit;
                if (timeout || (!p1_en_d && !p2_en_d)) begin
                    state_d  = ST_RESULT;
                    p1_dnf_d = p1_dnf || (timeout && p1_en_d);
                    p2_dnf_d = p2_dnf || (timeout && p2_en_d);
                    p1_en_d  = 1'b0;
                    p2_en_d  = 1'b0;
                    winner_d = pick_winner(p1_dnf_d, p2_dnf_d,
                                           p1_time_ms < p2_time_ms, p2_time_ms < p1_time_ms);
                end
                if (back_to_menu) state_d = ST_IDLE;
            end
            ST_RESULT: begin
                if (back_to_menu) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Every path into IDLE wipes the race record
        if (state_d == ST_IDLE) begin
            lights_d    = '0;
            p1_en_d     = 1'b0;
            p2_en_d     = 1'b0;
            p1_dnf_d    = 1'b0;
            p2_dnf_d    = 1'b0;
            winner_d    = WIN_NONE;
            phase_clear = 1'b1;
            restart_d   = (state_q != ST_IDLE);
        end
    end

    assign state  = state_q;
    assign winner = winner_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed self-checking bench for race_sequencer (LIGHT_MS=2, RACE_TIMEOUT_MS=1000, tick every 4 clk).
module tb_race_sequencer;

    localparam int unsigned TW = 20;

    logic          clk = 1'b0;
    logic          rst_n, tick_ms, start_game, back_to_menu, p1_throttle, p2_throttle;
    logic [31:0]   p1_pos, p2_pos;
    logic [2:0]    state, lights_on;
    logic          p1_enable, p2_enable, p1_dnf, p2_dnf, restart;
    logic [TW-1:0] p1_time_ms, p2_time_ms;
    logic [1:0]    winner;

    int total = 0;
    int bad   = 0;
    logic p1_en_seen = 1'b0;

    race_sequencer #(
        .FINISH_LINE_POS(1200), .NUM_LIGHTS(5), .LIGHT_MS(2),
        .RACE_TIMEOUT_MS(1000), .TIME_W(TW)
    ) dut (
        .clk(clk), .reset(rst_n), .tick_ms(tick_ms), .start_game(start_game),
        .back_to_menu(back_to_menu), .p1_throttle(p1_throttle), .p2_throttle(p2_throttle),
        .p1_pos(p1_pos), .p2_pos(p2_pos), .state(state), .lights_on(lights_on),
        .p1_enable(p1_enable), .p2_enable(p2_enable), .p1_time_ms(p1_time_ms),
        .p2_time_ms(p2_time_ms), .p1_dnf(p1_dnf), .p2_dnf(p2_dnf), .winner(winner),
        .restart(restart)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (p1_enable) p1_en_seen = 1'b1;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) tick_ms = 1'b1;
            @(negedge clk) tick_ms = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start_game = 1'b1;
        @(negedge clk) start_game = 1'b0;
    endtask

    task automatic pulse_menu();
        @(negedge clk) back_to_menu = 1'b1;
        @(negedge clk) back_to_menu = 1'b0;
    endtask

    task automatic go_to_race();
        p1_pos = 32'd0;
        p2_pos = 32'd0;
        pulse_start();
        ticks(12);
    endtask

    task automatic back_home();
        pulse_menu();
        p1_pos = 32'd0;
        p2_pos = 32'd0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({state, lights_on, p1_enable, p2_enable, p1_dnf, p2_dnf, winner, restart} !== 14'd0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {state, lights_on, p1_enable, p2_enable, p1_dnf, p2_dnf, winner, restart});
        end
        total++;
        if ({p1_time_ms, p2_time_ms} !== 40'd0) begin
            bad++; $display("FAIL reset_times: got %0d/%0d want 0/0", p1_time_ms, p2_time_ms);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_countdown();
        pulse_start();
        total++;
        if (state !== 3'd1 || lights_on !== 3'd0) begin
            bad++; $display("FAIL cd_enter: state %0d lights %0d want 1/0", state, lights_on);
        end
        for (int k = 1; k <= 5; k++) begin
            ticks(2);
            total++;
            if (lights_on !== 3'(k) || state !== 3'd1) begin
                bad++; $display("FAIL cd_light%0d: lights %0d state %0d want %0d/1", k, lights_on, state, k);
            end
        end
        ticks(1);
        total++;
        if (state !== 3'd1 || lights_on !== 3'd5) begin
            bad++; $display("FAIL cd_ms11: state %0d lights %0d want 1/5", state, lights_on);
        end
        ticks(1);
        total++;
        if (state !== 3'd2 || lights_on !== 3'd0 || p1_enable !== 1'b1 || p2_enable !== 1'b1) begin
            bad++; $display("FAIL cd_go: state %0d lights %0d en %b%b want 2/0/11", state, lights_on, p1_enable, p2_enable);
        end
    endtask

    task automatic test_finish_order();
        ticks(700);
        total++;
        if (p1_time_ms !== 20'd700 || p2_time_ms !== 20'd700) begin
            bad++; $display("FAIL order_700: got %0d/%0d want 700/700", p1_time_ms, p2_time_ms);
        end
        @(negedge clk) p1_pos = 32'd1200;
        @(negedge clk);
        total++;
        if (p1_enable !== 1'b0 || p2_enable !== 1'b1 || state !== 3'd2) begin
            bad++; $display("FAIL order_p1fin: en %b%b state %0d want 01/2", p1_enable, p2_enable, state);
        end
        ticks(200);
        total++;
        if (p1_time_ms !== 20'd700 || p2_time_ms !== 20'd900) begin
            bad++; $display("FAIL order_900: got %0d/%0d want 700/900", p1_time_ms, p2_time_ms);
        end
        // p2 crosses on a tick cycle: that tick must not count
        @(negedge clk) begin tick_ms = 1'b1; p2_pos = 32'd1250; end
        @(negedge clk) tick_ms = 1'b0;
        total++;
        if (p2_time_ms !== 20'd900 || state !== 3'd3 || winner !== 2'd1 || {p1_dnf, p2_dnf} !== 2'b00) begin
            bad++; $display("FAIL order_result: t2 %0d state %0d win %0d dnf %b%b want 900/3/1/00", p2_time_ms, state, winner, p1_dnf, p2_dnf);
        end
        pulse_menu();
        total++;
        if (state !== 3'd0 || restart !== 1'b1 || winner !== 2'd0 || p1_time_ms !== 20'd0) begin
            bad++; $display("FAIL order_menu: state %0d restart %b win %0d t1 %0d want 0/1/0/0", state, restart, winner, p1_time_ms);
        end
        p1_pos = 32'd0;
        p2_pos = 32'd0;
        @(negedge clk);
        total++;
        if (restart !== 1'b0) begin
            bad++; $display("FAIL order_restart_len: got %b want 0", restart);
        end
    endtask

    task automatic test_tie();
        go_to_race();
        ticks(5);
        @(negedge clk) begin p1_pos = 32'd1200; p2_pos = 32'd1300; end
        @(negedge clk);
        total++;
        if (state !== 3'd3 || winner !== 2'd3 || p1_time_ms !== 20'd5 || p2_time_ms !== 20'd5) begin
            bad++; $display("FAIL tie: state %0d win %0d t %0d/%0d want 3/3/5/5", state, winner, p1_time_ms, p2_time_ms);
        end
        back_home();
    endtask

    task automatic test_timeout();
        go_to_race();
        ticks(30);
        @(negedge clk) p2_pos = 32'd1200;
        @(negedge clk);
        ticks(969);
        total++;
        if (state !== 3'd2 || p1_dnf !== 1'b0 || p1_time_ms !== 20'd999) begin
            bad++; $display("FAIL timeout_pre: state %0d dnf1 %b t1 %0d want 2/0/999", state, p1_dnf, p1_time_ms);
        end
        ticks(1);
        total++;
        if (state !== 3'd3 || {p1_dnf, p2_dnf} !== 2'b10 || winner !== 2'd2 || p1_enable !== 1'b0) begin
            bad++; $display("FAIL timeout_res: state %0d dnf %b%b win %0d en1 %b want 3/10/2/0", state, p1_dnf, p2_dnf, winner, p1_enable);
        end
        total++;
        if (p1_time_ms !== 20'd1000 || p2_time_ms !== 20'd30) begin
            bad++; $display("FAIL timeout_times: got %0d/%0d want 1000/30", p1_time_ms, p2_time_ms);
        end
        ticks(3);
        total++;
        if (p1_time_ms !== 20'd1000 || state !== 3'd3) begin
            bad++; $display("FAIL timeout_frozen: t1 %0d state %0d want 1000/3", p1_time_ms, state);
        end
        back_home();
    endtask

    task automatic test_abort();
        pulse_start();
        ticks(5);
        pulse_menu();
        total++;
        if (state !== 3'd0 || restart !== 1'b1 || lights_on !== 3'd0) begin
            bad++; $display("FAIL abort_cd: state %0d restart %b lights %0d want 0/1/0", state, restart, lights_on);
        end
        @(negedge clk);
        total++;
        if (restart !== 1'b0) begin
            bad++; $display("FAIL abort_pulse: restart %b want 0", restart);
        end
        @(negedge clk) begin start_game = 1'b1; back_to_menu = 1'b1; end
        @(negedge clk) begin start_game = 1'b0; back_to_menu = 1'b0; end
        total++;
        if (state !== 3'd1 || restart !== 1'b0) begin
            bad++; $display("FAIL start_wins: state %0d restart %b want 1/0", state, restart);
        end
        ticks(2);
        pulse_start();
        total++;
        if (state !== 3'd1 || lights_on !== 3'd1) begin
            bad++; $display("FAIL start_ignored: state %0d lights %0d want 1/1", state, lights_on);
        end
        back_home();
        go_to_race();
        ticks(3);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (state !== 3'd0 || p1_enable !== 1'b0 || p1_time_ms !== 20'd0 || p2_time_ms !== 20'd0) begin
            bad++; $display("FAIL async_reset: state %0d en1 %b t %0d/%0d want 0/0/0/0", state, p1_enable, p1_time_ms, p2_time_ms);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_false_start();
        logic exp_dnf;
`ifdef FALSE_START_EN
        exp_dnf = 1'b1;
`else
        exp_dnf = 1'b0;
`endif
        p1_pos = 32'd0;
        p2_pos = 32'd0;
        pulse_start();
        ticks(10);
        p1_en_seen = 1'b0;
        @(negedge clk) p1_throttle = 1'b1;
        @(negedge clk) p1_throttle = 1'b0;
        ticks(2);
        total++;
        if (state !== 3'd2 || p1_dnf !== exp_dnf || p1_enable !== !exp_dnf || p2_enable !== 1'b1) begin
            bad++; $display("FAIL fs_go: state %0d dnf1 %b en %b%b want 2/%b/%b1", state, p1_dnf, p1_enable, p2_enable, exp_dnf, !exp_dnf);
        end
        ticks(10);
        @(negedge clk) p2_pos = 32'd1200;
        @(negedge clk);
        if (!exp_dnf) begin
            ticks(5);
            @(negedge clk) p1_pos = 32'd1200;
            @(negedge clk);
        end
        total++;
        if (state !== 3'd3 || winner !== 2'd2 || p1_dnf !== exp_dnf || p2_time_ms !== 20'd10) begin
            bad++; $display("FAIL fs_result: state %0d win %0d dnf1 %b t2 %0d want 3/2/%b/10", state, winner, p1_dnf, p2_time_ms, exp_dnf);
        end
        total++;
        if (p1_en_seen !== !exp_dnf || p1_time_ms !== (exp_dnf ? 20'd0 : 20'd15)) begin
            bad++; $display("FAIL fs_p1: en_seen %b t1 %0d want %b/%0d", p1_en_seen, p1_time_ms, !exp_dnf, exp_dnf ? 0 : 15);
        end
        back_home();
    endtask

    initial begin
        rst_n = 1'b0; tick_ms = 1'b0; start_game = 1'b0; back_to_menu = 1'b0;
        p1_throttle = 1'b0; p2_throttle = 1'b0; p1_pos = 32'd0; p2_pos = 32'd0;
        test_reset();
        test_countdown();
        test_finish_order();
        test_tie();
        test_timeout();
        test_abort();
        test_false_start();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
